matmul_mac_sequencer: RTL and testbench

//  Sequential multiply-accumulate engine computing R = A(2xK) * B(Kx4): 8 result elements, one MAC per clock.

---
 rtl/matmul_mac_sequencer.sv | 145 ++++++++++++++
 tb/tb_matmul_mac_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/matmul_mac_sequencer.sv
// Sequential MAC engine computing R = A(2xK) * B(Kx4), one multiply-accumulate per clock,
// streaming each finished element to the register file. Define MATMUL_SAT_EN to saturate instead of wrap.
module matmul_mac_sequencer #(
  parameter int ELEM_W = 3,
  parameter int K_DIM  = 2,
  parameter int OUT_W  = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [2*K_DIM*ELEM_W-1:0]   a_flat,
  input  logic [4*K_DIM*ELEM_W-1:0]   b_flat,
  output logic [OUT_W-1:0]            product_out,
  output logic [3:0]                  reg_specifier,
  output logic                        update_reg,
  output logic                        busy,
  output logic                        done
);

  localparam int ACC_W = 2*ELEM_W + $clog2(K_DIM) + 1;
  localparam logic [3:0] K_LAST = 4'(K_DIM - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_DONE} state_t;

  state_t                      state_q, state_d;
  logic [2*K_DIM*ELEM_W-1:0]   a_q, a_d;
  logic [4*K_DIM*ELEM_W-1:0]   b_q, b_d;
  logic [ACC_W-1:0]            acc_q, acc_d;
  logic [2:0]                  i_q, i_d;
  logic [3:0]                  k_q, k_d;
  logic [OUT_W-1:0]            product_q, product_d;
  logic [2:0]                  spec_q, spec_d;
  logic                        upd_q, upd_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  logic [ELEM_W-1:0]           a_el, b_el;
  logic [ACC_W-1:0]            sum;

  // Result formatting toward the narrower register-file element.
  function automatic logic [OUT_W-1:0] fmt(input logic [ACC_W-1:0] v);
`ifdef MATMUL_SAT_EN
    if ((v >> OUT_W) != '0) return '1;
    return OUT_W'(v);
`else
    return OUT_W'(v);
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    i_d       = i_q;
    k_d       = k_q;
    product_d = product_q;
    spec_d    = spec_q;
    upd_d     = upd_q;
    busy_d    = busy_q;
    done_d    = done_q;

    // Row of A comes from index bit 2, column of B from bits 1:0.
    a_el = a_q[(int'(i_q[2])*K_DIM + int'(k_q))*ELEM_W +: ELEM_W];
    b_el = b_q[(int'(k_q)*4 + int'(i_q[1:0]))*ELEM_W +: ELEM_W];
    sum  = acc_q + ACC_W'(a_el) * ACC_W'(b_el);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a_flat;
          b_d     = b_flat;
          i_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          busy_d  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = sum;
        if (k_q == K_LAST) begin
          product_d = fmt(sum);
          spec_d    = i_q;
          upd_d     = 1'b1;
          state_d   = S_WRITE;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_WRITE: begin
        upd_d = 1'b0;
        acc_d = '0;
        k_d   = '0;
        if (i_q == 3'd7) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          i_d     = i_q + 3'd1;
          state_d = S_MAC;
        end
      end
      default: begin
        done_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      i_q       <= '0;
      k_q       <= '0;
      product_q <= '0;
      spec_q    <= '0;
      upd_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      k_q       <= k_d;
      product_q <= product_d;
      spec_q    <= spec_d;
      upd_q     <= upd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign product_out   = product_q;
  assign reg_specifier = {1'b0, spec_q};
  assign update_reg    = upd_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_matmul_mac_sequencer.sv
// Directed bench for matmul_mac_sequencer: scoreboard of expected (index, value) pairs
// popped on every update_reg strobe, plus per-edge timing checks of strobe/busy/done.
module tb_matmul_mac_sequencer;
  localparam int E = 3;
  localparam int K = 2;
  localparam int O = 6;
  localparam int LAST = 8*(K+1);   // edge on which done rises

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [2*K*E-1:0]     a_flat = '0;
  logic [4*K*E-1:0]     b_flat = '0;
  logic [O-1:0]         product_out;
  logic [3:0]           reg_specifier;
  logic                 update_reg, busy, done;

  int total = 0;
  int fails = 0;
  int sb_spec[$];
  int sb_val[$];
  int ma[2][K];
  int mb[K][4];

  matmul_mac_sequencer #(.ELEM_W(E), .K_DIM(K), .OUT_W(O)) dut (
    .clk(clk), .reset(reset), .start(start), .a_flat(a_flat), .b_flat(b_flat),
    .product_out(product_out), .reg_specifier(reg_specifier),
    .update_reg(update_reg), .busy(busy), .done(done));

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int fmt_model(input int v);
`ifdef MATMUL_SAT_EN
    return (v > (1<<O)-1) ? (1<<O)-1 : v;
`else
    return v % (1<<O);
`endif
  endfunction

  // Pack the model matrices onto the operand buses and queue the expected results.
  task automatic load_and_expect();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < K; k++) a_flat[(r*K+k)*E +: E] = ma[r][k][E-1:0];
    for (int k = 0; k < K; k++)
      for (int c = 0; c < 4; c++) b_flat[(k*4+c)*E +: E] = mb[k][c][E-1:0];
    for (int i = 0; i < 8; i++) begin
      int s = 0;
      for (int k = 0; k < K; k++) s += ma[i/4][k] * mb[k][i%4];
      sb_spec.push_back(i);
      sb_val.push_back(fmt_model(s));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (update_reg === 1'b1) begin
      total++;
      assert (sb_spec.size() > 0) else begin
        fails++;
        $error("FAIL sb_empty: observed strobe spec %0d expected no strobe", reg_specifier);
      end
      if (sb_spec.size() > 0) begin
        check("spec", int'(reg_specifier), sb_spec.pop_front());
        check("product", int'(product_out), sb_val.pop_front());
      end
    end
  endtask

  // One run from the accepting edge e0 through IDLE after e(LAST+1), with timing checks per edge.
  task automatic run(input bit hold, input int p1, input int p2, input bit chg);
    start = 1'b1;
    step();
    start = hold;
    check("busy_e0", int'(busy), 1);
    check("upd_e0", int'(update_reg), 0);
    for (int n = 1; n <= LAST + 1; n++) begin
      start = hold || (n == p1) || (n == p2);
      if (chg && n == 6) a_flat = (2*K*E)'($urandom);
      step();
      check($sformatf("upd_e%0d", n), int'(update_reg),
            (n >= K && n < LAST && (n-K) % (K+1) == 0) ? 1 : 0);
      check($sformatf("busy_e%0d", n), int'(busy), (n < LAST) ? 1 : 0);
      check($sformatf("done_e%0d", n), int'(done), (n == LAST) ? 1 : 0);
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_product", int'(product_out), 0);
    check("rst_spec", int'(reg_specifier), 0);
    check("rst_upd", int'(update_reg), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    step();
    reset = 1'b0;
    step();

    // Identity-like A against a mixed B
    ma = '{'{1, 0}, '{0, 1}};
    mb = '{'{1, 2, 3, 4}, '{5, 6, 7, 0}};
    load_and_expect();
    run(1'b0, -1, -1, 1'b0);
    check("sb_drained_1", sb_spec.size(), 0);

    // Asynchronous reset mid-MAC after e3
    load_and_expect();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 3; n++) step();
    reset = 1'b1;
    #1;
    check("mid_rst_product", int'(product_out), 0);
    check("mid_rst_spec", int'(reg_specifier), 0);
    check("mid_rst_upd", int'(update_reg), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    sb_spec.delete();
    sb_val.delete();
    step();
    reset = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      check("post_rst_upd", int'(update_reg), 0);
      check("post_rst_busy", int'(busy), 0);
    end

    // All-max operands: 98 wraps to 34 or saturates to 63
    for (int r = 0; r < 2; r++) for (int k = 0; k < K; k++) ma[r][k] = 7;
    for (int k = 0; k < K; k++) for (int c = 0; c < 4; c++) mb[k][c] = 7;
    load_and_expect();
    run(1'b0, -1, -1, 1'b0);
    check("sb_drained_2", sb_spec.size(), 0);

    // Start pulses at e4/e10 and operand change mid-run are ignored
    ma = '{'{2, 3}, '{1, 5}};
    mb = '{'{3, 1, 0, 2}, '{4, 6, 7, 1}};
    load_and_expect();
    run(1'b0, 4, 10, 1'b1);
    step();
    check("no_restart_busy", int'(busy), 0);
    check("sb_drained_3", sb_spec.size(), 0);

    // Start held high: back-to-back runs, second captured right after done
    ma = '{'{4, 1}, '{6, 2}};
    mb = '{'{1, 5, 2, 3}, '{7, 0, 4, 6}};
    load_and_expect();
    load_and_expect();
    run(1'b1, -1, -1, 1'b0);
    run(1'b1, -1, -1, 1'b0);
    start = 1'b0;
    step();
    check("held_idle_busy", int'(busy), 0);
    check("sb_drained_4", sb_spec.size(), 0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
